// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg
//   Shared definitions for the two-master IO bus arbiter: bus width
//   constants and the arbiter FSM state encoding.
package io_bus_arbiter_pkg;

   localparam int unsigned IO_BUS_WIDTH_DATA = 32;
   localparam int unsigned IO_BUS_WIDTH_ADDR = 32;
   localparam int unsigned IO_BUS_WIDTH_CTRL = 3;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2,
      ARB_TURN = 2'd3
   } arb_state_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if
//   Bundles both masters' beat/handshake signals and the shared BUS side.
//   Modports:
//     slave  - arbiter view (master beats and bus_rd in; grants, valids,
//              read data and bus drive out)
//     master - environment view (the reverse direction)
interface io_bus_arbiter_if
   import io_bus_arbiter_pkg::*;
#(
   parameter int unsigned DW = IO_BUS_WIDTH_DATA,
   parameter int unsigned AW = IO_BUS_WIDTH_ADDR,
   parameter int unsigned CW = IO_BUS_WIDTH_CTRL
) ();

   logic          m0_req,   m1_req;
   logic          m0_last,  m1_last;
   logic          m0_we,    m1_we;
   logic [AW-1:0] m0_addr,  m1_addr;
   logic [CW-1:0] m0_ctrl,  m1_ctrl;
   logic [DW-1:0] m0_wd,    m1_wd;
   logic          m0_gnt,   m1_gnt;
   logic          m0_valid, m1_valid;
   logic [DW-1:0] m0_rd,    m1_rd;

   logic [AW-1:0] bus_addr;
   logic [CW-1:0] bus_ctrl;
   logic [DW-1:0] bus_wd;
   logic          bus_we;
   logic [DW-1:0] bus_rd;

   modport slave (
      input  m0_req, m0_last, m0_we, m0_addr, m0_ctrl, m0_wd,
      input  m1_req, m1_last, m1_we, m1_addr, m1_ctrl, m1_wd,
      input  bus_rd,
      output m0_gnt, m0_valid, m0_rd,
      output m1_gnt, m1_valid, m1_rd,
      output bus_addr, bus_ctrl, bus_wd, bus_we
   );

   modport master (
      output m0_req, m0_last, m0_we, m0_addr, m0_ctrl, m0_wd,
      output m1_req, m1_last, m1_we, m1_addr, m1_ctrl, m1_wd,
      output bus_rd,
      input  m0_gnt, m0_valid, m0_rd,
      input  m1_gnt, m1_valid, m1_rd,
      input  bus_addr, bus_ctrl, bus_wd, bus_we
   );

endinterface

// File: rtl/arb_hold_timer.sv
// arb_hold_timer
//   Saturating 8-bit hold counter for the current bus owner.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     i_clr     - clear counter to 0 (held while no master owns the bus)
//     i_en      - count one granted cycle
//     o_expire  - counter has reached MAX_HOLD-1
module arb_hold_timer #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [7:0] LP_LIMIT = 8'(MAX_HOLD - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LP_LIMIT)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_expire = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Two-master round-robin arbiter for the shared IO bus with bounded
//   hold time and a one-cycle turnaround on every ownership change.
//   Ports:
//     clk, rst - clock, asynchronous active-high reset
//     bus      - io_bus_arbiter_if.slave: master beats in, grants/valids/
//                read data out, shared BUS drive (addr/ctrl/wd/we) out
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int unsigned DW       = IO_BUS_WIDTH_DATA,
   parameter int unsigned AW       = IO_BUS_WIDTH_ADDR,
   parameter int unsigned CW       = IO_BUS_WIDTH_CTRL,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst,
   io_bus_arbiter_if.slave bus
);

   arb_state_t r_state;
   logic       r_m0_gnt;
   logic       r_m1_gnt;
   logic       r_m0_valid;
   logic       r_m1_valid;
   logic       r_rr_last;

   logic          w_own;
   logic          w_expire;
   logic          w_rel0;
   logic          w_rel1;
   logic [AW-1:0] w_addr;
   logic [CW-1:0] w_ctrl;
   logic [DW-1:0] w_wd;
   logic          w_we;

   assign w_own = (r_state == ARB_OWN0) || (r_state == ARB_OWN1);

   arb_hold_timer #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (!w_own),
      .i_en     (w_own),
      .o_expire (w_expire)
   );

   // Release on completion, on an idle cycle, or on hold expiry while the
   // other master waits; the beat in the releasing cycle still issues.
   assign w_rel0 = !bus.m0_req || bus.m0_last || (w_expire && bus.m1_req);
   assign w_rel1 = !bus.m1_req || bus.m1_last || (w_expire && bus.m0_req);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_m0_gnt   <= 1'b0;
         r_m1_gnt   <= 1'b0;
         r_m0_valid <= 1'b0;
         r_m1_valid <= 1'b0;
         r_rr_last  <= 1'b1;
      end else begin
         // Read-data valid follows a granted read beat regardless of
         // whether the grant is dropped at this same edge.
         r_m0_valid <= (r_state == ARB_OWN0) && bus.m0_req && !bus.m0_we;
         r_m1_valid <= (r_state == ARB_OWN1) && bus.m1_req && !bus.m1_we;
         case (r_state)
            ARB_IDLE: begin
               if (bus.m0_req && (!bus.m1_req || r_rr_last)) begin
                  r_state  <= ARB_OWN0;
                  r_m0_gnt <= 1'b1;
               end else if (bus.m1_req) begin
                  r_state  <= ARB_OWN1;
                  r_m1_gnt <= 1'b1;
               end
            end
            ARB_OWN0: begin
               if (w_rel0) begin
                  r_state   <= ARB_TURN;
                  r_m0_gnt  <= 1'b0;
                  r_rr_last <= 1'b0;
               end
            end
            ARB_OWN1: begin
               if (w_rel1) begin
                  r_state   <= ARB_TURN;
                  r_m1_gnt  <= 1'b0;
                  r_rr_last <= 1'b1;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      w_addr = '0;
      w_ctrl = '0;
      w_wd   = '0;
      w_we   = 1'b0;
      case (r_state)
         ARB_OWN0: begin
            w_addr = bus.m0_addr;
            w_ctrl = bus.m0_ctrl;
            w_wd   = bus.m0_wd;
            w_we   = bus.m0_req && bus.m0_we;
         end
         ARB_OWN1: begin
            w_addr = bus.m1_addr;
            w_ctrl = bus.m1_ctrl;
            w_wd   = bus.m1_wd;
            w_we   = bus.m1_req && bus.m1_we;
         end
         default: begin
         end
      endcase
   end

   assign bus.bus_addr = w_addr;
   assign bus.bus_ctrl = w_ctrl;
   assign bus.bus_wd   = w_wd;
   assign bus.bus_we   = w_we;
   assign bus.m0_gnt   = r_m0_gnt;
   assign bus.m1_gnt   = r_m1_gnt;
   assign bus.m0_valid = r_m0_valid;
   assign bus.m1_valid = r_m1_valid;
   assign bus.m0_rd    = bus.bus_rd;
   assign bus.m1_rd    = bus.bus_rd;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
//   Bench for io_bus_arbiter (MAX_HOLD=4): directed scenarios plus random
//   traffic, compared each cycle against a behavioural ownership model.
module tb_io_bus_arbiter;

   localparam int MH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req  [2];
   logic        last [2];
   logic        we   [2];
   logic [31:0] addr [2];
   logic [2:0]  ctrl [2];
   logic [31:0] wd   [2];
   logic [31:0] bus_rd;

   int n_chk  = 0;
   int n_pass = 0;
   int we_seen = 0;

   // model: current owner (-1 none), turnaround cycles left, last served,
   // cycles held so far, expected valids after the edge, beat owner
   int mo_owner, mo_gap, mo_last, mo_ten, mo_beat;
   bit mo_v [2];

   io_bus_arbiter_if #(.DW(32), .AW(32), .CW(3)) ifc ();

   assign ifc.m0_req  = req[0];
   assign ifc.m0_last = last[0];
   assign ifc.m0_we   = we[0];
   assign ifc.m0_addr = addr[0];
   assign ifc.m0_ctrl = ctrl[0];
   assign ifc.m0_wd   = wd[0];
   assign ifc.m1_req  = req[1];
   assign ifc.m1_last = last[1];
   assign ifc.m1_we   = we[1];
   assign ifc.m1_addr = addr[1];
   assign ifc.m1_ctrl = ctrl[1];
   assign ifc.m1_wd   = wd[1];
   assign ifc.bus_rd  = bus_rd;

   io_bus_arbiter #(
      .DW       (32),
      .AW       (32),
      .CW       (3),
      .MAX_HOLD (MH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic void model_reset();
      mo_owner = -1;
      mo_gap   = 0;
      mo_last  = 1;
      mo_ten   = 0;
      mo_beat  = -1;
      mo_v[0]  = 0;
      mo_v[1]  = 0;
   endfunction

   // One clock edge of the arbitration rules, using the inputs at the edge.
   function automatic void model_step();
      automatic int o = mo_owner;
      mo_v[0] = 0;
      mo_v[1] = 0;
      mo_beat = -1;
      if (rst) begin
         model_reset();
      end else if (o >= 0) begin
         mo_ten++;
         if (req[o]) begin
            mo_beat = o;
            if (!we[o]) mo_v[o] = 1;
         end
         if (!req[o] || last[o] || (mo_ten >= MH && req[1-o])) begin
            mo_last  = o;
            mo_owner = -1;
            mo_gap   = 1;
         end
      end else if (mo_gap > 0) begin
         mo_gap--;
      end else if (req[0] && req[1]) begin
         mo_owner = 1 - mo_last;
         mo_ten   = 0;
      end else if (req[0] || req[1]) begin
         mo_owner = req[0] ? 0 : 1;
         mo_ten   = 0;
      end
   endfunction

   task automatic check_comb();
      automatic logic [31:0] e_addr = '0;
      automatic logic [31:0] e_wd   = '0;
      automatic logic [2:0]  e_ctrl = '0;
      automatic logic        e_we   = 1'b0;
      if (mo_owner >= 0) begin
         e_addr = addr[mo_owner];
         e_wd   = wd[mo_owner];
         e_ctrl = ctrl[mo_owner];
         e_we   = req[mo_owner] && we[mo_owner];
      end
      check_val("bus_we",   ifc.bus_we,   e_we);
      check_val("bus_addr", ifc.bus_addr, e_addr);
      check_val("bus_ctrl", ifc.bus_ctrl, e_ctrl);
      check_val("bus_wd",   ifc.bus_wd,   e_wd);
      check_val("m0_rd",    ifc.m0_rd,    bus_rd);
      check_val("m1_rd",    ifc.m1_rd,    bus_rd);
      if (ifc.bus_we === 1'b1) we_seen++;
   endtask

   task automatic check_reg();
      check_val("m0_gnt",   ifc.m0_gnt,   mo_owner == 0);
      check_val("m1_gnt",   ifc.m1_gnt,   mo_owner == 1);
      check_val("m0_valid", ifc.m0_valid, mo_v[0]);
      check_val("m1_valid", ifc.m1_valid, mo_v[1]);
      check_val("gnt_excl", ifc.m0_gnt & ifc.m1_gnt, 1'b0);
   endtask

   // Called at a negedge with inputs set; returns at the next negedge.
   task automatic run_cycle();
      #1;
      check_comb();
      @(posedge clk);
      model_step();
      #1;
      check_reg();
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      for (int m = 0; m < 2; m++) begin
         // a waiting master holds its beat stable
         if (!(req[m] && mo_owner != m)) begin
            req[m]  = ($urandom_range(0, 3) != 0);
            last[m] = ($urandom_range(0, 3) == 0);
            we[m]   = $urandom_range(0, 1);
            addr[m] = $urandom;
            ctrl[m] = 3'($urandom);
            wd[m]   = $urandom;
         end
      end
      bus_rd = $urandom;
   endtask

   initial begin
      int nb;
      model_reset();
      for (int m = 0; m < 2; m++) begin
         req[m] = 1'b1; last[m] = 1'b0; we[m] = 1'b1;
         addr[m] = 32'h1000 * (m + 1); ctrl[m] = 3'd2; wd[m] = 32'hC0DE0000 + m;
      end
      bus_rd = 32'h0;
      #1 rst = 1'b1;

      // reset with both requesting: everything quiet, then m0 wins
      @(negedge clk);
      run_cycle();
      run_cycle();
      rst = 1'b0;
      run_cycle();
      check_val("first_gnt_m0", ifc.m0_gnt, 1'b1);
      check_val("first_gnt_m1", ifc.m1_gnt, 1'b0);

      // both request continuously without last: alternating bounded tenures
      for (int i = 0; i < 30; i++) run_cycle();

      // m0 3-beat write burst, m1 silent
      req[0] = 1'b0; req[1] = 1'b0;
      for (int i = 0; i < 4; i++) run_cycle();
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hFFFFF060;
      nb = 0;
      we_seen = 0;
      for (int i = 0; i < 20 && nb < 3; i++) begin
         last[0] = (nb == 2);
         wd[0]   = 32'hB0000000 + nb;
         run_cycle();
         if (mo_beat == 0) nb++;
      end
      check_val("burst_done", nb, 3);
      req[0] = 1'b0; last[0] = 1'b0;
      for (int i = 0; i < 3; i++) run_cycle();
      check_val("burst_we_cycles", we_seen, 3);

      // m1 single read, data returned the cycle after the beat
      req[1] = 1'b1; we[1] = 1'b0; last[1] = 1'b1; addr[1] = 32'hFFFFF070;
      bus_rd = 32'h00A5A5A5;
      nb = 0;
      for (int i = 0; i < 10 && nb == 0; i++) begin
         run_cycle();
         if (mo_beat == 1) nb = 1;
      end
      check_val("read_issued", nb, 1);
      check_val("m1_valid_pulse", ifc.m1_valid, 1'b1);
      check_val("m1_rd_data", ifc.m1_rd, 32'h00A5A5A5);
      check_val("m0_valid_quiet", ifc.m0_valid, 1'b0);
      req[1] = 1'b0; last[1] = 1'b0;
      for (int i = 0; i < 3; i++) run_cycle();

      // m0 drops req without last while m1 waits
      req[0] = 1'b1; we[0] = 1'b1; last[0] = 1'b0;
      for (int i = 0; i < 6 && mo_owner != 0; i++) run_cycle();
      req[1] = 1'b1; we[1] = 1'b1;
      req[0] = 1'b0;
      for (int i = 0; i < 5; i++) run_cycle();
      check_val("m1_after_drop", ifc.m1_gnt, 1'b1);
      req[1] = 1'b0;
      for (int i = 0; i < 4; i++) run_cycle();

      // asynchronous reset during an m0 burst
      req[0] = 1'b1; req[1] = 1'b1; last[0] = 1'b0; last[1] = 1'b0;
      we[0] = 1'b1;
      for (int i = 0; i < 12 && mo_owner != 0; i++) run_cycle();
      check_val("pre_rst_owner", ifc.m0_gnt, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_val("async_gnt", ifc.m0_gnt, 1'b0);
      check_val("async_we",  ifc.bus_we, 1'b0);
      model_reset();
      @(negedge clk);
      run_cycle();
      rst = 1'b0;
      run_cycle();
      check_val("rr_restart_m0", ifc.m0_gnt, 1'b1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         rand_inputs();
         run_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
